// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end: issues word addresses to a synchronous-read icache,
// captures the returned word one cycle later and queues {pc, inst} for decode.
module fetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] icache_addr,
    input  logic [31:0] icache_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Handshake: an entry transfers to decode in a cycle where out_valid and
    // out_ready are both high at the rising edge; out_valid never depends on out_ready.

    logic [31:0]   fetch_pc;
    logic [31:0]   pending_pc;
    logic          pending_valid;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [31:0] mem_pc   [DEPTH];
    logic [31:0] mem_inst [DEPTH];

    logic [31:0] issue_pc;
    logic [CW:0] in_flight;
    logic        issue;
    logic        push;
    logic        pop;

    always_comb begin
        issue_pc    = redirect_valid ? (redirect_pc & ~32'h3) : fetch_pc;
        icache_addr = issue_pc[31:2];
        // Credit check counts the outstanding fetch but not a same-cycle pop,
        // so a captured word always finds a free slot.
        in_flight   = {1'b0, count} + {{CW{1'b0}}, pending_valid};
        issue       = redirect_valid | (in_flight < (CW+1)'(DEPTH));
        push        = pending_valid & ~redirect_valid;
        out_valid   = (count != '0) & ~redirect_valid;
        pop         = out_valid & out_ready;
        out_inst    = mem_inst[rd_ptr];
        out_pc      = mem_pc[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc      <= RESET_PC & ~32'h3;
            pending_pc    <= '0;
            pending_valid <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else begin
            pending_valid <= issue;
            if (issue) begin
                pending_pc <= issue_pc;
                fetch_pc   <= issue_pc + 32'd4;
            end
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage carries no reset; contents are only observed behind out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= pending_pc;
            mem_inst[wr_ptr] <= icache_data;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer: a one-cycle-latency cache image
// feeds the DUT and an expected {pc, inst} queue is checked on every accepted output.
module tb_fetch_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] icache_addr;
    logic [31:0] icache_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .icache_addr(icache_addr), .icache_data(icache_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Cache image: word k holds 0x1000 + k inside the mapped range, 0 outside.
    function automatic logic [31:0] img(input logic [29:0] a);
        return (a < 30'h100) ? (32'h1000 + {2'b00, a}) : 32'h0;
    endfunction

    always @(posedge clk) icache_data <= img(icache_addr);

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, img(pc[31:2])});
    endtask

    task automatic push_run(input logic [31:0] pc0, input int n);
        for (int i = 0; i < n; i++) push_exp(pc0 + 32'(4 * i));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic ready_after);
        next_cycle();
        rst       = 1'b1;
        out_ready = 1'b0;
        next_cycle();
        rst       = 1'b0;
        out_ready = ready_after;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got pc 0x%08h inst 0x%08h, expected none",
                         out_pc, out_inst);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("out_pc", out_pc, e[63:32]);
                check("out_inst", out_inst, e[31:0]);
            end
        end
    end

    initial begin
        // Reset state and first-issue latency
        repeat (2) @(posedge clk);
        sample();
        check("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check("reset_icache_addr", {2'b0, icache_addr}, 32'h0);
        next_cycle();
        rst = 1'b0;
        push_run(32'h0, 6);
        sample();
        check("c0_out_valid", {31'b0, out_valid}, 32'h0);
        check("c0_icache_addr", {2'b0, icache_addr}, 32'h0);
        next_cycle();
        sample();
        check("c1_out_valid", {31'b0, out_valid}, 32'h0);
        next_cycle();
        sample();
        check("c2_out_valid", {31'b0, out_valid}, 32'h1);
        repeat (5) next_cycle();

        // Stall until full, then drain
        do_reset(1'b0);
        push_run(32'h0, 8);
        repeat (5) next_cycle();
        for (int i = 0; i < 5; i++) begin
            sample();
            check("stall_out_valid", {31'b0, out_valid}, 32'h1);
            check("stall_out_pc", out_pc, 32'h0);
            check("stall_icache_addr", {2'b0, icache_addr}, 32'h4);
            next_cycle();
        end
        out_ready = 1'b1;
        repeat (7) next_cycle();
        next_cycle();
        out_ready = 1'b0;

        // Redirect with 3 queued entries and one pending fetch
        do_reset(1'b1);
        push_run(32'h0, 3);
        repeat (4) next_cycle();
        next_cycle();
        out_ready = 1'b0;
        repeat (2) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        out_ready      = 1'b1;
        push_run(32'h40, 2);
        sample();
        check("redir_out_valid", {31'b0, out_valid}, 32'h0);
        check("redir_icache_addr", {2'b0, icache_addr}, 32'h10);
        next_cycle();
        redirect_valid = 1'b0;
        repeat (2) next_cycle();
        next_cycle();
        out_ready = 1'b0;

        // Unaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        push_run(32'h40, 2);
        sample();
        check("redir42_out_valid", {31'b0, out_valid}, 32'h0);
        check("redir42_icache_addr", {2'b0, icache_addr}, 32'h10);
        next_cycle();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (2) next_cycle();

        // Back-to-back redirects: last one wins
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        sample();
        check("b2b0_out_valid", {31'b0, out_valid}, 32'h0);
        check("b2b0_icache_addr", {2'b0, icache_addr}, 32'h20);
        next_cycle();
        redirect_pc = 32'h100;
        push_run(32'h100, 2);
        sample();
        check("b2b1_out_valid", {31'b0, out_valid}, 32'h0);
        check("b2b1_icache_addr", {2'b0, icache_addr}, 32'h40);
        next_cycle();
        redirect_valid = 1'b0;
        repeat (2) next_cycle();
        next_cycle();
        out_ready = 1'b0;

        // Asynchronous reset mid-cycle with two entries queued
        next_cycle();
        #2;
        check("pre_rst_out_valid", {31'b0, out_valid}, 32'h1);
        check("pre_rst_out_pc", out_pc, 32'h108);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", {31'b0, out_valid}, 32'h0);
        next_cycle();
        next_cycle();
        rst       = 1'b0;
        out_ready = 1'b1;
        push_run(32'h0, 4);
        repeat (5) next_cycle();
        next_cycle();
        out_ready = 1'b0;
        repeat (3) next_cycle();

        check("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction cache.
- Generates word addresses for the cache's synchronous read port and captures the returned instruction one cycle later.
- Queues each instruction with its PC in a small FIFO and hands it to decode over a valid/ready handshake.
- Handles redirects (branch, jump, exception) by flushing all queued and in-flight fetches.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- icache_addr  out  30  word address [31:2] to the cache read port; the cache returns data one cycle later.
- icache_data  in  32  instruction from the cache, valid in the cycle after its address was sampled.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored.
- out_valid  out  1  head entry is available.
- out_ready  in  1  decode accepts the head entry.
- out_inst  out  32  head instruction.
- out_pc  out  32  head PC; bits [1:0] always 0.

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high.
- While rst is high:
  - fetch_pc = RESET_PC.
  - FIFO empty: rd_ptr = wr_ptr = count = 0.
  - pending_valid = 0.
  - out_valid = 0.
  - out_inst and out_pc read the entry-0 contents, which are don't-care.
- Storage: per-entry {pc, inst}. Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Issue:
  - icache_addr = redirect_valid ? redirect_pc[31:2] : fetch_pc[31:2]. It is combinational.
  - issue = redirect_valid | (count + pending_valid < DEPTH). The credit check ignores a same-cycle pop, so space is guaranteed at capture.
  - On issue: pending_valid <= 1, pending_pc <= issued address, fetch_pc <= issued address + 4 (32-bit wrap).
  - No issue: pending_valid <= 0 and fetch_pc holds. The cache read still happens and its result is ignored.
- Capture: in a cycle with pending_valid = 1 and redirect_valid = 0, push {pending_pc, icache_data} at the rising edge.
- Pop: when out_valid & out_ready, advance rd_ptr.
- Simultaneous push and pop: count is unchanged; a push into the slot just popped is legal.
- out_valid = (count != 0) & ~redirect_valid. out_inst and out_pc come from the head entry.
- Latency:
  - An address issued in cycle N appears at the FIFO head (out_valid = 1) in cycle N+2.
  - Steady state with out_ready = 1 delivers one instruction per cycle.
  - The first out_valid after rst deassertion comes 2 cycles after the first issue.
- Full (count = DEPTH): no issue. Outputs hold stable until popped; no entry is ever dropped or duplicated.
- Redirect (one-cycle pulse, honoured any cycle), at the rising edge:
  - count, rd_ptr, wr_ptr <= 0.
  - The in-flight pending data is discarded, not pushed.
  - A pop in the same cycle is ignored.
  - The target is issued in the same cycle: pending_pc <= {redirect_pc[31:2], 2'b00}, fetch_pc <= that + 4.
  - The first post-redirect instruction is valid 2 cycles later.
- Back-to-back redirects: the last one wins; an earlier target never reaches the output.
- Addresses outside the cache range return 0 from the cache. The block passes them through unchanged and performs no checking.
- Reset mid-operation: immediate asynchronous clear; fetch restarts at RESET_PC after release.

Test Plan:
- Reset, then hold out_ready = 1 with cache image word k = 0x1000+k -> out_pc sequence 0x0, 0x4, 0x8, ... with out_inst 0x1000, 0x1001, ...; first out_valid 2 cycles after the first issue, then every cycle.
- out_ready = 0 for 10 cycles -> count saturates at 4, issues stop (pending_valid = 0), head holds out_pc = 0x0. Release -> PCs 0x0..0x1C in order, no gaps or repeats.
- Pulse redirect_valid with redirect_pc = 0x40 while the FIFO holds 3 entries and one fetch is pending -> out_valid low that cycle, next delivered out_pc = 0x40, then 0x44; the stale PCs 0x0C..0x18 never appear.
- Redirect to 0x42 -> icache_addr = 0x10, first out_pc = 0x40.
- Redirects on two consecutive cycles (0x80 then 0x100) -> first output PC is 0x100.
- Assert rst asynchronously mid-cycle with the FIFO half full -> out_valid drops immediately without a clock edge; after release, the stream restarts at RESET_PC.
